// File: rtl/pc_sequencer.sv
// Program-counter sequencer: holds the architectural PC, drives the fetch request,
// resolves jumps/branches and redirects misaligned control-flow targets to a trap vector.
module pc_sequencer #(
    parameter int              XLEN    = 32,
    parameter logic [XLEN-1:0] INITPC  = '0,
    parameter logic [XLEN-1:0] TRAPVEC = XLEN'(32'h0000_0100),
    parameter bit              CALIGN  = 1'b0
) (
    input  logic            clk,
    input  logic            nRST,
    input  logic [5:0]      cuOP,
    input  logic [XLEN-1:0] rs1Read,
    input  logic [XLEN-1:0] signExtend,
    input  logic            Zero,
    input  logic            ALUneg,
    input  logic            iready,
    input  logic            halt,
    output logic [XLEN-1:0] PCaddr,
    output logic [XLEN-1:0] pc_plus4,
    output logic            iren,
    output logic            trap_valid,
    output logic [XLEN-1:0] trap_epc,
    output logic            halted
);

    localparam logic [5:0] OP_JAL  = 6'd2;
    localparam logic [5:0] OP_JALR = 6'd3;
    localparam logic [5:0] OP_BEQ  = 6'd4;
    localparam logic [5:0] OP_BNE  = 6'd5;
    localparam logic [5:0] OP_BLT  = 6'd6;
    localparam logic [5:0] OP_BGE  = 6'd7;
    localparam logic [5:0] OP_BLTU = 6'd8;
    localparam logic [5:0] OP_BGEU = 6'd9;

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_FETCH = 2'd1,
        ST_TRAP  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    state_t          state_reg, state_next;
    logic [XLEN-1:0] pc_reg, pc_next;
    logic [XLEN-1:0] epc_reg, epc_next;

    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] br_target;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] target;
    logic            is_jalr;
    logic            redirect;
    logic            misaligned;

    // Target resolution is purely combinational so it can be used on the retiring edge.
    always_comb begin
        seq_pc    = pc_reg + XLEN'(4);
        br_target = pc_reg + signExtend;
        jalr_sum  = rs1Read + signExtend;
        is_jalr   = (cuOP == OP_JALR);
        redirect  = 1'b0;
        case (cuOP)
            OP_JAL, OP_JALR:  redirect = 1'b1;
            OP_BEQ:           redirect = Zero;
            OP_BNE:           redirect = !Zero;
            OP_BLT, OP_BLTU:  redirect = ALUneg;
            OP_BGE, OP_BGEU:  redirect = !ALUneg;
            default:          redirect = 1'b0;
        endcase
        target = is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : br_target;
        if (CALIGN)
            misaligned = redirect && !is_jalr && target[0];
        else
            misaligned = redirect && target[1];
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_reg <= ST_RST;
            pc_reg    <= INITPC;
            epc_reg   <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            epc_reg   <= epc_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        epc_next   = epc_reg;
        case (state_reg)
            ST_RST:   state_next = ST_FETCH;
            ST_FETCH: begin
                // halt wins over a retiring instruction
                if (halt) begin
                    state_next = ST_HALT;
                end else if (iready) begin
                    if (misaligned) begin
                        pc_next    = TRAPVEC;
                        epc_next   = pc_reg;
                        state_next = ST_TRAP;
                    end else begin
                        pc_next = redirect ? target : seq_pc;
                    end
                end
            end
            ST_TRAP:  state_next = ST_FETCH;
            ST_HALT:  state_next = ST_HALT;
            default:  state_next = ST_RST;
        endcase
    end

    assign PCaddr     = pc_reg;
    assign pc_plus4   = pc_reg + XLEN'(4);
    assign iren       = (state_reg == ST_FETCH);
    assign trap_valid = (state_reg == ST_TRAP);
    assign trap_epc   = epc_reg;
    assign halted     = (state_reg == ST_HALT);

endmodule
